// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of a single-ported data memory.
// The CPU and the debug/IO master share one memory port with a round-robin
// tie-break. dbg_lock keeps the CPU off the port entirely. Reads return one
// cycle after the grant, steered back to whichever port issued them.
module dmem_port_arbiter #(
  parameter int DATA_W   = 8,
  parameter int D_ADDR_W = 12
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [D_ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                cpu_gnt,
  output logic                cpu_rvalid,
  output logic [DATA_W-1:0]   cpu_rdata,
  input  logic                dbg_req,
  input  logic                dbg_we,
  input  logic [D_ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0]   dbg_wdata,
  output logic                dbg_gnt,
  output logic                dbg_rvalid,
  output logic [DATA_W-1:0]   dbg_rdata,
  input  logic                dbg_lock,
  output logic                mem_en,
  output logic                mem_we,
  output logic [D_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  owner_e last_grant;
  owner_e rd_owner;
  logic   rd_pending;
  logic   cpu_elig;
  logic   dbg_elig;
  logic   rd_issue;

  // Grant decision: purely from requests, dbg_lock and last_grant, so
  // mem_rdata can never reach a grant.
  always_comb begin
    cpu_gnt  = 1'b0;
    dbg_gnt  = 1'b0;
    cpu_elig = cpu_req & ~dbg_lock;
    dbg_elig = dbg_req;
    if (cpu_elig && dbg_elig) begin
      if (last_grant == OWN_DBG) cpu_gnt = 1'b1;
      else                       dbg_gnt = 1'b1;
    end else begin
      cpu_gnt = cpu_elig;
      dbg_gnt = dbg_elig;
    end
  end

  // Memory port mux; everything is driven to zero when nobody is granted.
  always_comb begin
    mem_en    = cpu_gnt | dbg_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  assign rd_issue = mem_en & ~mem_we;

  // Round-robin history: remember who got the port last; reset favours the CPU.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= OWN_DBG;
    end else if (cpu_gnt) begin
      last_grant <= OWN_CPU;
    end else if (dbg_gnt) begin
      last_grant <= OWN_DBG;
    end
  end

  // Read tracking: a granted read produces exactly one return next cycle.
  // rd_owner holds when no read is issued; only rd_pending qualifies it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pending <= 1'b0;
      rd_owner   <= OWN_CPU;
    end else begin
      rd_pending <= rd_issue;
      if (rd_issue) begin
        rd_owner <= dbg_gnt ? OWN_DBG : OWN_CPU;
      end
    end
  end

  // Read return steering; dbg_lock deliberately plays no part here so an
  // already-issued CPU read still completes.
  always_comb begin
    cpu_rvalid = rd_pending & (rd_owner == OWN_CPU);
    dbg_rvalid = rd_pending & (rd_owner == OWN_DBG);
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed, table-driven bench for dmem_port_arbiter.
module tb_dmem_port_arbiter;

  localparam int DATA_W   = 8;
  localparam int D_ADDR_W = 12;

  logic                clk;
  logic                reset_n;
  logic                cpu_req, cpu_we;
  logic [D_ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0]   cpu_wdata;
  logic                cpu_gnt, cpu_rvalid;
  logic [DATA_W-1:0]   cpu_rdata;
  logic                dbg_req, dbg_we;
  logic [D_ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0]   dbg_wdata;
  logic                dbg_gnt, dbg_rvalid;
  logic [DATA_W-1:0]   dbg_rdata;
  logic                dbg_lock;
  logic                mem_en, mem_we;
  logic [D_ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  int errors = 0;
  int checks = 0;

  dmem_port_arbiter #(.DATA_W(DATA_W), .D_ADDR_W(D_ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dbg_lock(dbg_lock),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle: {cpu_gnt, dbg_gnt, mem_en, mem_we, mem_addr, mem_wdata,
  //                 cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata}
  typedef logic [41:0] obus_t;

  typedef struct {
    logic        c_req, c_we;
    logic [11:0] c_addr;
    logic [7:0]  c_wd;
    logic        d_req, d_we;
    logic [11:0] d_addr;
    logic [7:0]  d_wd;
    logic        lock;
    logic [7:0]  mrd;
    obus_t       exp;
  } vec_t;

  vec_t vecs[$];

  function automatic obus_t mk(input logic cg, input logic dg, input logic en, input logic we,
                               input logic [11:0] a, input logic [7:0] wd,
                               input logic crv, input logic [7:0] crd,
                               input logic drv, input logic [7:0] drd);
    return {cg, dg, en, we, a, wd, crv, crd, drv, drd};
  endfunction

  function automatic obus_t sample();
    return {cpu_gnt, dbg_gnt, mem_en, mem_we, mem_addr, mem_wdata,
            cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata};
  endfunction

  task automatic add(input logic c_req, input logic c_we, input logic [11:0] c_addr, input logic [7:0] c_wd,
                     input logic d_req, input logic d_we, input logic [11:0] d_addr, input logic [7:0] d_wd,
                     input logic lock, input logic [7:0] mrd, input obus_t exp);
    vec_t v;
    v.c_req = c_req; v.c_we = c_we; v.c_addr = c_addr; v.c_wd = c_wd;
    v.d_req = d_req; v.d_we = d_we; v.d_addr = d_addr; v.d_wd = d_wd;
    v.lock = lock; v.mrd = mrd; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    cpu_req = v.c_req; cpu_we = v.c_we; cpu_addr = v.c_addr; cpu_wdata = v.c_wd;
    dbg_req = v.d_req; dbg_we = v.d_we; dbg_addr = v.d_addr; dbg_wdata = v.d_wd;
    dbg_lock = v.lock; mem_rdata = v.mrd;
  endtask

  task automatic check(input string name, input obus_t got, input obus_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    dbg_lock = 0; mem_rdata = '0;
  endtask

  obus_t z;

  initial begin
    z = '0;
    // c_req c_we c_addr c_wd | d_req d_we d_addr d_wd | lock mrd | expected
    add(0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,8'h00, z);
    add(1,0,12'h010,8'h00, 0,0,12'h000,8'h00, 0,8'h00, mk(1,0,1,0,12'h010,8'h00, 0,8'h00,0,8'h00));
    add(0,0,12'h000,8'h00, 1,1,12'hFFF,8'h3C, 0,8'hA5, mk(0,1,1,1,12'hFFF,8'h3C, 1,8'hA5,0,8'h00));
    add(0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,8'h77, z);
    add(1,0,12'h100,8'h00, 1,0,12'h200,8'h5A, 0,8'h00, mk(1,0,1,0,12'h100,8'h00, 0,8'h00,0,8'h00));
    add(1,0,12'h100,8'h00, 1,0,12'h200,8'h5A, 0,8'h11, mk(0,1,1,0,12'h200,8'h5A, 1,8'h11,0,8'h00));
    add(1,0,12'h100,8'h00, 1,0,12'h200,8'h5A, 0,8'h22, mk(1,0,1,0,12'h100,8'h00, 0,8'h00,1,8'h22));
    add(1,0,12'h100,8'h00, 1,0,12'h200,8'h5A, 0,8'h33, mk(0,1,1,0,12'h200,8'h5A, 1,8'h33,0,8'h00));
    add(0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,8'h44, mk(0,0,0,0,12'h000,8'h00, 0,8'h00,1,8'h44));
    for (int i = 0; i < 5; i++)
      add(1,0,12'h055,8'h00, 0,0,12'h000,8'h00, 1,8'h99, z);
    add(1,0,12'h055,8'h00, 0,0,12'h000,8'h00, 0,8'h00, mk(1,0,1,0,12'h055,8'h00, 0,8'h00,0,8'h00));
    add(1,0,12'h066,8'h00, 0,0,12'h000,8'h00, 1,8'h5E, mk(0,0,0,0,12'h000,8'h00, 1,8'h5E,0,8'h00));
    add(1,0,12'h066,8'h00, 0,0,12'h000,8'h00, 1,8'h12, z);
    add(1,0,12'h066,8'h00, 1,0,12'h300,8'h00, 1,8'h00, mk(0,1,1,0,12'h300,8'h00, 0,8'h00,0,8'h00));
    add(1,0,12'h066,8'h00, 1,0,12'h300,8'h00, 1,8'h6C, mk(0,1,1,0,12'h300,8'h00, 0,8'h00,1,8'h6C));
    add(0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,8'h01, mk(0,0,0,0,12'h000,8'h00, 0,8'h00,1,8'h01));
    add(1,1,12'h0AB,8'hC3, 0,0,12'h000,8'h00, 0,8'hFF, mk(1,0,1,1,12'h0AB,8'hC3, 0,8'h00,0,8'h00));
    add(0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,8'hEE, z);

    // Reset state
    reset_n = 1'b0;
    idle_inputs();
    mem_rdata = 8'hA5;
    #2;
    check("reset_outputs", sample(), z);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Table vectors, one per cycle; state carries from row to row.
    foreach (vecs[i]) begin
      drive(vecs[i]);
      #2;
      check($sformatf("vec%0d", i), sample(), vecs[i].exp);
      @(negedge clk);
    end

    // CPU read granted, then reset pulsed before its return.
    idle_inputs();
    cpu_req = 1; cpu_addr = 12'h010;
    #2;
    check("rst_seq_grant", sample(), mk(1,0,1,0,12'h010,8'h00, 0,8'h00,0,8'h00));
    @(negedge clk);
    idle_inputs();
    mem_rdata = 8'hA5;
    reset_n = 1'b0;
    #2;
    check("rst_drops_rvalid", sample(), z);
    cpu_req = 1; cpu_addr = 12'h020;
    #1;
    check("rst_gnt_comb", sample(), mk(1,0,1,0,12'h020,8'h00, 0,8'h00,0,8'h00));
    @(negedge clk);
    reset_n = 1'b1;
    idle_inputs();
    mem_rdata = 8'h5C;
    cpu_req = 1; cpu_addr = 12'h030;
    dbg_req = 1; dbg_addr = 12'h040;
    #2;
    check("rst_last_grant_dbg", sample(), mk(1,0,1,0,12'h030,8'h00, 0,8'h00,0,8'h00));
    @(negedge clk);
    cpu_req = 0;
    #2;
    check("post_rst_return", sample(), mk(0,1,1,0,12'h040,8'h00, 1,8'h5C,0,8'h00));
    @(negedge clk);
    idle_inputs();
    mem_rdata = 8'h9D;
    #2;
    check("post_rst_dbg_return", sample(), mk(0,0,0,0,12'h000,8'h00, 0,8'h00,1,8'h9D));
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
